// File: rtl/friscv_imem_loader.sv
// Streams a length-prefixed little-endian byte image into instruction memory
// and holds the core in reset until the whole image has been written.
module friscv_imem_loader #(
   parameter int ARCH             = 32,
   parameter int IMEM_ADDR_WIDTH  = 12,
   parameter int IMEM_DEPTH_WORDS = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_in,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid_in,
   output logic                       byte_ready_out,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_out,
   output logic [ARCH-1:0]            imem_wdata_out,
   output logic                       imem_we_out,
   output logic                       core_rst_out,
   output logic                       done_out,
   output logic                       err_out
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   state_t                     state_q, state_d;
   logic [15:0]                count_q, count_d;
   logic [15:0]                word_idx_q, word_idx_d;
   logic [1:0]                 byte_idx_q, byte_idx_d;
   logic [23:0]                shift_q, shift_d;
   logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ARCH-1:0]            wdata_q, wdata_d;

   logic                       ready_s;
   logic                       xfer_s;
   logic [15:0]                new_count_s;
   logic [15:0]                word_idx_inc_s;

   assign ready_s        = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
   assign xfer_s         = byte_valid_in && ready_s;
   assign new_count_s    = {byte_in, count_q[7:0]};
   assign word_idx_inc_s = word_idx_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_in) begin
               state_d    = LEN_LO;
               word_idx_d = 16'd0;
               byte_idx_d = 2'd0;
            end else begin
               state_d = state_q;
            end
         end
         LEN_LO: begin
            if (xfer_s) begin
               count_d[7:0] = byte_in;
               state_d      = LEN_HI;
            end else begin
               state_d = LEN_LO;
            end
         end
         LEN_HI: begin
            if (xfer_s) begin
               count_d = new_count_s;
               if (new_count_s == 16'd0) begin
                  state_d = DONE;
               end else if ({16'd0, new_count_s} > 32'(IMEM_DEPTH_WORDS)) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = LEN_HI;
            end
         end
         DATA: begin
            if (xfer_s) begin
               if (byte_idx_q == 2'd3) begin
                  // The fourth byte goes straight into the write word, not the shifter.
                  state_d    = WRITE;
                  byte_idx_d = 2'd0;
                  addr_d     = IMEM_ADDR_WIDTH'({word_idx_q, 2'b00});
                  wdata_d    = ARCH'({byte_in, shift_q});
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0:    shift_d[7:0]   = byte_in;
                     2'd1:    shift_d[15:8]  = byte_in;
                     2'd2:    shift_d[23:16] = byte_in;
                     default: shift_d        = shift_q;
                  endcase
               end
            end else begin
               state_d = DATA;
            end
         end
         WRITE: begin
            word_idx_d = word_idx_inc_s;
            if (word_idx_inc_s == count_q) begin
               state_d = DONE;
            end else begin
               state_d = DATA;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= 16'd0;
         word_idx_q <= 16'd0;
         byte_idx_q <= 2'd0;
         shift_q    <= 24'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   // Status outputs decode directly from the state register.
   assign byte_ready_out = ready_s;
   assign imem_we_out    = (state_q == WRITE);
   assign done_out       = (state_q == DONE);
   assign err_out        = (state_q == ERROR);
   assign core_rst_out   = (state_q != DONE);
   assign imem_addr_out  = addr_q;
   assign imem_wdata_out = wdata_q;

endmodule

// File: doc/friscv_imem_loader.md
FRISCV_IMEM_LOADER -- requirements
Module: friscv_imem_loader

Interface
REQ-001 SHALL have parameter ARCH, default 32, data word width in bits.
REQ-002 SHALL have parameter IMEM_ADDR_WIDTH, default 12, byte-address width of instruction memory.
REQ-003 SHALL have parameter IMEM_DEPTH_WORDS, default 1024, maximum loadable word count.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start_in  input  1  single-cycle load request.
REQ-007 SHALL have port byte_in  input  8  stream byte.
REQ-008 SHALL have port byte_valid_in  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready_out  output  1  loader accepts byte.
REQ-010 SHALL have port imem_addr_out  output  IMEM_ADDR_WIDTH  instruction-memory write byte address.
REQ-011 SHALL have port imem_wdata_out  output  ARCH  instruction-memory write data.
REQ-012 SHALL have port imem_we_out  output  1  instruction-memory write enable.
REQ-013 SHALL have port core_rst_out  output  1  active-high hold-in-reset for the core.
REQ-014 SHALL have port done_out  output  1  load complete.
REQ-015 SHALL have port err_out  output  1  load rejected.

Function
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
REQ-017 SHALL define a byte transfer as byte_valid_in=1 and byte_ready_out=1 on the same rising edge.
REQ-018 SHALL drive byte_ready_out=1 only in LEN_LO, LEN_HI and DATA.
REQ-019 IDLE: SHALL go to LEN_LO when start_in=1.
REQ-020 LEN_LO: on transfer, SHALL latch count[7:0] and go to LEN_HI.
REQ-021 LEN_HI: on transfer, SHALL latch count[15:8]; next state DONE if the 16-bit count is 0, ERROR if it exceeds IMEM_DEPTH_WORDS, else DATA.
REQ-022 DATA: SHALL assemble 4 bytes little-endian (first byte -> bits 7:0); on the 4th transfer SHALL go to WRITE.
REQ-023 WRITE: SHALL assert imem_we_out for exactly one cycle, with imem_addr_out = word_idx*4 truncated to IMEM_ADDR_WIDTH and imem_wdata_out = the assembled word.
REQ-024 On leaving WRITE, SHALL increment word_idx; next state DONE if the new word_idx equals count, else DATA.
REQ-025 DONE: SHALL drive done_out=1 and core_rst_out=0.
REQ-026 ERROR: SHALL drive err_out=1 and core_rst_out=1.
REQ-027 In DONE or ERROR, start_in=1 SHALL go to LEN_LO and clear word_idx, done_out and err_out.
REQ-028 start_in SHALL be ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-029 core_rst_out SHALL be 1 in every state except DONE.
REQ-030 imem_we_out SHALL be 0 outside WRITE.
REQ-031 imem_addr_out and imem_wdata_out SHALL hold their last values outside WRITE.
REQ-032 Word data SHALL be write-only; the loader never reads memory.
REQ-033 Byte stalls (byte_valid_in=0) SHALL freeze state and the byte index with no timeout.

Reset
REQ-034 rst=1 SHALL force IDLE and clear count, word_idx and byte index.
REQ-035 rst=1 SHALL clear imem_addr_out, imem_wdata_out, imem_we_out, done_out, err_out and byte_ready_out to 0, and set core_rst_out=1.
REQ-036 rst SHALL take priority over start_in and any in-progress transfer, including mid-WRITE, where imem_we_out SHALL be 0 in the following cycle.

Verification
REQ-037 Bytes 02 00 13 00 00 00 93 00 10 00 after start -> two writes: addr 0x000 data 0x00000013, then addr 0x004 data 0x00100093; then done_out=1, core_rst_out=0.
REQ-038 Count 0 (00 00) -> DONE with no imem_we_out pulse.
REQ-039 Count IMEM_DEPTH_WORDS+1 (01 04) -> ERROR, err_out=1, core_rst_out=1, no write.
REQ-040 Random byte_valid_in gaps on the REQ-037 stream -> identical writes; byte_ready_out=0 in every WRITE cycle.
REQ-041 rst asserted after the 5th byte -> IDLE with all outputs at reset values; a new start with a full stream loads correctly from addr 0.
REQ-042 start_in pulsed mid-DATA -> ignored; start_in in DONE -> second load overwrites from addr 0x000.
